// File: rtl/fifo_pkg.sv
// Shared types and helpers for the extended synchronous FIFO queue.
// No logic of its own; sizing helper and an integrator-facing status bundle.
// Backpressure: n/a (declarations only).
package fifo_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Flag bundle for integrators who want to route the status as one bus.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_queue_ext_mem.sv
// DEPTH x DATA_WIDTH simple dual-port storage: one synchronous write port, one async read port.
// Latency: write visible on read port the cycle after the write edge; read is combinational.
// Backpressure: none; the owner decides when a write is legal.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_queue_ext.sv
// Single-clock FIFO with occupancy count, almost flags, sticky errors, flush and optional FWFT.
// Latency: FWFT=0 data_out one cycle after the deq edge; FWFT=1 head shown combinationally.
// Backpressure: enq refused when full unless a deq frees a slot that cycle; refusals set sticky flags.
module fifo_queue_ext
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq,
    input  logic                    deq,
    input  logic                    flush,
    input  logic                    err_clr,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_LVL  = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL  = PW'(AE_THRESH);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] head_dat;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  deq_ok;
    logic                  enq_ok;
    logic                  mem_we;

    // All flags come from the registered pointers only, never from enq/deq.
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    // A deq on a full queue frees the slot the enq then overwrites, so both may go.
    assign deq_ok = deq && !empty;
    assign enq_ok = enq && (!full || deq_ok);
    assign mem_we = reset && !flush && enq_ok;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head_dat)
    );

    // Pointer update: reset beats flush beats normal traffic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq_ok) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (!flush && enq && !enq_ok) overflow <= 1'b1;
            else if (err_clr)             overflow <= 1'b0;
            if (!flush && deq && !deq_ok) underflow <= 1'b1;
            else if (err_clr)             underflow <= 1'b0;
        end
    end

    // Registered read port: capture the head on each accepted deq; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_q <= '0;
        end else if (!flush && deq_ok) begin
            dout_q <= head_dat;
        end
    end

    assign data_out = (FWFT != 0) ? head_dat : dout_q;

endmodule

// File: tb/tb_fifo_queue_ext.sv
module tb_fifo_queue_ext;

    logic       clk = 1'b0;
    logic       reset, enq, deq, flush, err_clr;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic       full0, empty0, af0, ae0, ov0, un0;
    logic       full1, empty1, af1, ae1, ov1, un1;
    logic [4:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue plus flags computed from its size.
    logic [7:0] q[$];
    logic       m_ov, m_un;
    logic [7:0] m_dout;

    always #5 clk = ~clk;

    fifo_queue_ext #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_reg (
        .clk(clk), .reset(reset), .enq(enq), .deq(deq), .flush(flush), .err_clr(err_clr),
        .data_in(data_in), .data_out(dout0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0)
    );

    fifo_queue_ext #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fwft (
        .clk(clk), .reset(reset), .enq(enq), .deq(deq), .flush(flush), .err_clr(err_clr),
        .data_in(data_in), .data_out(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the queue rules to the inputs present at this edge.
    task automatic model_edge();
        bit d_ok, e_ok;
        if (!reset) begin
            q.delete();
            m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00;
        end else if (flush) begin
            q.delete();
        end else begin
            d_ok = deq && (q.size() > 0);
            e_ok = enq && ((q.size() < 16) || d_ok);
            if (d_ok) m_dout = q.pop_front();
            if (e_ok) q.push_back(data_in);
            if (enq && !e_ok) m_ov = 1'b1; else if (err_clr) m_ov = 1'b0;
            if (deq && !d_ok) m_un = 1'b1; else if (err_clr) m_un = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(cnt0), 32'(q.size()));
        chk({tag, ".full"},  32'(full0), 32'(q.size() == 16));
        chk({tag, ".empty"}, 32'(empty0), 32'(q.size() == 0));
        chk({tag, ".af"},    32'(af0), 32'(q.size() >= 14));
        chk({tag, ".ae"},    32'(ae0), 32'(q.size() <= 2));
        chk({tag, ".ovf"},   32'(ov0), 32'(m_ov));
        chk({tag, ".udf"},   32'(un0), 32'(m_un));
        chk({tag, ".dout"},  32'(dout0), 32'(m_dout));
        chk({tag, ".f_count"}, 32'(cnt1), 32'(q.size()));
        chk({tag, ".f_flags"}, 32'({ov1, un1, full1, empty1}),
            32'({m_ov, m_un, q.size() == 16, q.size() == 0}));
        if (q.size() > 0) chk({tag, ".f_head"}, 32'(dout1), 32'(q[0]));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        enq = 1'b0; deq = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b0; data_in = 8'h00; idle();
        m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00;

        // Reset values
        tick("reset0");
        tick("reset1");
        reset = 1'b1;
        tick("post_reset");

        // Fill 0..15, then one rejected enq
        for (int i = 0; i < 16; i++) begin
            enq = 1'b1; data_in = 8'(i);
            tick($sformatf("fill%0d", i));
        end
        chk("fill.af_at16", 32'(af0), 32'd1);
        data_in = 8'hEE;
        tick("overflow_enq");
        chk("overflow.count", 32'(cnt0), 32'd16);
        idle();

        // Drain in order with registered read
        for (int i = 0; i < 16; i++) begin
            deq = 1'b1;
            tick($sformatf("drain%0d", i));
            chk($sformatf("drain%0d.val", i), 32'(dout0), 32'(i));
        end
        tick("underflow_deq");
        chk("underflow.flag", 32'(un0), 32'd1);
        idle();

        // Simultaneous enq/deq on a full queue
        for (int i = 1; i <= 16; i++) begin
            enq = 1'b1; data_in = 8'(i);
            tick($sformatf("refill%0d", i));
        end
        enq = 1'b1; deq = 1'b1; data_in = 8'hA5;
        tick("full_enq_deq");
        chk("full_enq_deq.count", 32'(cnt0), 32'd16);
        idle();
        for (int i = 0; i < 16; i++) begin
            deq = 1'b1;
            tick($sformatf("drain2_%0d", i));
            chk($sformatf("drain2_%0d.val", i), 32'(dout0), (i == 15) ? 32'hA5 : 32'(i + 2));
        end
        idle();

        // Fall-through head visible without a deq
        enq = 1'b1; data_in = 8'h3C;
        tick("fwft_enq");
        idle();
        tick("fwft_hold");
        chk("fwft.head", 32'(dout1), 32'h3C);
        deq = 1'b1;
        tick("fwft_deq");
        chk("fwft.empty", 32'(empty1), 32'd1);
        idle();

        // Flush with a concurrent enq, then clear errors
        for (int i = 0; i < 5; i++) begin
            enq = 1'b1; data_in = 8'(8'h50 + i);
            tick($sformatf("push%0d", i));
        end
        flush = 1'b1; enq = 1'b1; data_in = 8'h77;
        tick("flush");
        chk("flush.count", 32'(cnt0), 32'd0);
        idle();
        tick("after_flush");
        err_clr = 1'b1;
        tick("err_clr");
        chk("err_clr.flags", 32'({ov0, un0}), 32'd0);
        idle();

        // Random traffic with a mid-stream reset
        for (int c = 0; c < 40; c++) begin
            idle();
            reset   = (c == 20) ? 1'b0 : 1'b1;
            enq     = ($urandom_range(0, 99) < 60);
            deq     = ($urandom_range(0, 99) < 45);
            err_clr = ($urandom_range(0, 99) < 5);
            data_in = 8'($urandom);
            tick($sformatf("rand%0d", c));
            if (c == 20) begin
                chk("rand_reset.count", 32'(cnt0), 32'd0);
                chk("rand_reset.dout", 32'(dout0), 32'd0);
            end
        end
        reset = 1'b1; idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
